// File: rtl/arb_pkg.sv
// Shared sizing and FSM encoding for the 32-way round-robin arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arb_pkg;

  localparam int N_REQ  = 32;
  localparam int IDX_W  = 5;
  localparam int HOLD_W = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick_32.sv
// Wrap-around priority search: first set req bit at or after ptr, 31 wraps to 0.
// Latency: purely combinational, zero cycles.
// Backpressure: none; any=0 when no requester is active.
module rr_pick_32
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] off;

  assign any = |req;

  // Rotate so ptr lands on bit 0, then the lowest set bit is the nearest requester.
  // Index arithmetic is IDX_W wide, so ptr+i wraps modulo 32 by construction.
  always_comb begin
    rot = '0;
    off = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[ptr + IDX_W'(i)];
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = IDX_W'(i);
      end
    end
  end

  assign idx = ptr + off;

endmodule

// File: rtl/rr_arbiter_32.sv
// 32-way round-robin arbiter for a shared 32:1 mux; optional hold watchdog under ARB_TIMEOUT_EN.
// Latency: grant one cycle after req seen in IDLE; at least one IDLE cycle between grants.
// Backpressure: owner keeps the grant until release_grant, its req drops, or the watchdog fires.
module rr_arbiter_32
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  // The owner's end-of-grant pulse; the bare name collides with a reserved word.
  input  logic             release_grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] grant_onehot,
  output logic             timeout
);

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_nx;
  logic [IDX_W-1:0] idx_nx;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             expired;

  rr_pick_32 u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt;
  logic              revoke;

  // Hold counter: zero while idle so each grant starts from zero, counts GRANTED cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state == GRANTED) begin
      hold_cnt <= hold_cnt + 1'b1;
    end else begin
      hold_cnt <= '0;
    end
  end

  assign expired = (state == GRANTED) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  // A grant that would have ended anyway on this edge is not reported as revoked.
  assign revoke  = expired && !release_grant && req[grant_idx];

  // Timeout pulse is high for the IDLE cycle that follows a watchdog revoke.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout <= 1'b0;
    end else begin
      timeout <= revoke;
    end
  end
`else
  // Watchdog compiled out: never expires (the parameter is still referenced here).
  assign expired = 1'b0 && (MAX_HOLD > 0);
  assign timeout = 1'b0;
`endif

  // State, pointer and owner registers; reset drops any grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_idx <= '0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      grant_idx <= idx_nx;
    end
  end

  // Next-state: arbitrate only in IDLE; in GRANTED watch for the end of the grant.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    idx_nx   = grant_idx;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nx = GRANTED;
          idx_nx   = pick_idx;
        end
      end
      GRANTED: begin
        if (release_grant || !req[grant_idx] || expired) begin
          state_nx = IDLE;
          ptr_nx   = grant_idx + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign grant_valid  = (state == GRANTED);
  assign grant_onehot = grant_valid ? (N_REQ'(1) << grant_idx) : '0;

endmodule

// File: tb/tb_rr_arbiter_32.sv
module tb_rr_arbiter_32;

  localparam int HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] req = '0;
  logic        rel = 1'b0;
  logic        grant_valid;
  logic [4:0]  grant_idx;
  logic [31:0] grant_onehot;
  logic        timeout;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: owner (-1 = none), search pointer, last owner, GRANTED cycles done, timeout flag
  int m_owner;
  int m_ptr;
  int m_last;
  int m_hold;
  bit m_to;

  rr_arbiter_32 #(.MAX_HOLD(HOLD)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .release_grant(rel),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_last  = 0;
    m_hold  = 0;
    m_to    = 1'b0;
  endtask

  // What happens at the next rising edge given the inputs held across it.
  task automatic model_advance(input logic [31:0] r, input logic rl);
    bit found;
    m_to = 1'b0;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < 32; k++) begin
        int c;
        c = (m_ptr + k) % 32;
        if (!found && r[c]) begin
          found   = 1'b1;
          m_owner = c;
          m_last  = c;
          m_hold  = 0;
        end
      end
    end else begin
      if (rl || !r[m_owner]) begin
        m_ptr   = (m_owner + 1) % 32;
        m_owner = -1;
      end else if (TO_EN && (m_hold + 1 >= HOLD)) begin
        m_ptr   = (m_owner + 1) % 32;
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_hold = m_hold + 1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] exp_oh;
    exp_oh = '0;
    if (m_owner >= 0) exp_oh[m_owner] = 1'b1;
    chk({tag, ".valid"},   32'(grant_valid),  32'(m_owner >= 0));
    chk({tag, ".idx"},     32'(grant_idx),    32'(m_last));
    chk({tag, ".onehot"},  grant_onehot,      exp_oh);
    chk({tag, ".timeout"}, 32'(timeout),      32'(m_to));
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, check 1ns later.
  task automatic step(input string tag, input logic [31:0] r, input logic rl);
    @(negedge clk);
    req = r;
    rel = rl;
    model_advance(r, rl);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0;
    rel = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #1 check_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    // Single requester: grant after one cycle, release, one IDLE cycle, re-grant
    step("r26_grant", 32'h0000_0001, 1'b0);
    chk("r26_first_idx", 32'(grant_idx), 32'd0);
    step("r26_rel", 32'h0000_0001, 1'b1);
    chk("r26_idle", 32'(grant_valid), 32'd0);
    step("r26_regrant", 32'h0000_0001, 1'b0);
    chk("r26_regrant_v", 32'(grant_valid), 32'd1);
    step("r26_rel2", 32'h0000_0001, 1'b1);
    step("idle_release_ignored", 32'h0, 1'b1);
    step("idle_empty", 32'h0, 1'b0);

    // All requesting: strict rotation 0..31 then 0
    do_reset();
    for (int g = 0; g < 33; g++) begin
      step("r27_grant", 32'hFFFF_FFFF, 1'b0);
      chk("r27_owner", 32'(grant_idx), 32'(g % 32));
      step("r27_hold", 32'hFFFF_FFFF, 1'b0);
      step("r27_rel", 32'hFFFF_FFFF, 1'b1);
    end

    // Pointer at 31 after owner 30: bits 0 and 2 must wrap to 0, then 2
    step("r28_own30", 32'h4000_0000, 1'b0);
    step("r28_rel30", 32'h4000_0000, 1'b1);
    step("r28_g0", 32'h0000_0005, 1'b0);
    chk("r28_wrap0", 32'(grant_idx), 32'd0);
    step("r28_rel0", 32'h0000_0005, 1'b1);
    step("r28_g2", 32'h0000_0005, 1'b0);
    chk("r28_then2", 32'(grant_idx), 32'd2);
    step("r28_rel2", 32'h0000_0005, 1'b1);

    // Owner 3 drops its request while 7 waits
    step("r29_g3", 32'h0000_0088, 1'b0);
    chk("r29_owner3", 32'(grant_idx), 32'd3);
    step("r29_drop", 32'h0000_0080, 1'b0);
    chk("r29_idle", 32'(grant_valid), 32'd0);
    step("r29_g7", 32'h0000_0080, 1'b0);
    chk("r29_owner7", 32'(grant_idx), 32'd7);
    step("r17_nopreempt", 32'h0000_FFFF, 1'b0);
    step("r29_rel7", 32'h0000_0080, 1'b1);

    // Asynchronous reset in the middle of owner 12's grant
    step("r31_g12", 32'h0000_1010, 1'b0);
    chk("r31_owner12", 32'(grant_idx), 32'd12);
    #2;
    req = '0;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("r31_async");
    @(negedge clk);
    rst = 1'b0;
    step("r31_from0", 32'h0000_1010, 1'b0);
    chk("r31_owner4", 32'(grant_idx), 32'd4);
    step("r31_rel", 32'h0000_1010, 1'b1);

`ifdef ARB_TIMEOUT_EN
    // Watchdog: req[9] held, revoked after HOLD GRANTED cycles; release beats expiry
    do_reset();
    for (int i = 0; i < HOLD; i++) step("r30_hold", 32'h0000_0200, 1'b0);
    chk("r30_still9", 32'(grant_valid), 32'd1);
    step("r30_expire", 32'h0000_0200, 1'b0);
    chk("r30_timeout", 32'(timeout), 32'd1);
    step("r30_regrant", 32'h0000_0200, 1'b0);
    chk("r30_owner9", 32'(grant_idx), 32'd9);
    for (int i = 1; i < HOLD; i++) step("r30_hold2", 32'h0000_0200, 1'b0);
    step("r30_rel_wins", 32'h0000_0200, 1'b1);
    chk("r30_no_timeout", 32'(timeout), 32'd0);
`endif

    // Randomised traffic against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [31:0] r;
      logic        rl;
      case ($urandom_range(0, 4))
        0:       r = '0;
        1:       r = $urandom;
        2:       r = 32'h1 << $urandom_range(0, 31);
        default: r = $urandom & $urandom & $urandom;
      endcase
      rl = ($urandom_range(0, 3) == 0);
      step("rand", r, rl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_32.md
RR_ARBITER_32 -- requirements
Module: rr_arbiter_32

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16: maximum grant length in cycles when the timeout feature is compiled in (1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req, input, 32, per-requester request; bit i = requester i.
REQ-005 SHALL have port release, input, 1, single-cycle pulse from the current owner ending its grant.
REQ-006 SHALL have port grant_valid, output, 1, high while a grant is held.
REQ-007 SHALL have port grant_idx, output, 5, index of the current owner; drives the select input of the shared 32:1 mux.
REQ-008 SHALL have port grant_onehot, output, 32, one-hot of grant_idx when grant_valid is high, else zero.
REQ-009 SHALL have port timeout, output, 1, one-cycle pulse when a grant is revoked by the hold watchdog.

Function
REQ-010 SHALL implement the states IDLE and GRANTED only.
REQ-011 In IDLE with req nonzero, SHALL pick the first set req bit at or after ptr, searching upward and wrapping 31->0, and enter GRANTED on the next edge; grant latency is exactly 1 cycle.
REQ-012 In IDLE with req zero, SHALL stay in IDLE with outputs at their reset values.
REQ-013 In GRANTED, SHALL hold grant_idx constant until release=1, or req[grant_idx]=0, or a timeout.
REQ-014 On any grant end, SHALL set ptr to grant_idx+1 mod 32 (31 wraps to 0) and return to IDLE for at least one cycle with grant_valid=0.
REQ-015 release seen in IDLE SHALL be ignored.
REQ-016 If release and the timeout occur in the same cycle, release SHALL win and timeout SHALL stay 0.
REQ-017 Requests arriving during GRANTED SHALL NOT pre-empt the owner; they are arbitrated in the next IDLE cycle.
REQ-018 grant_idx SHALL hold its last value in IDLE; consumers qualify it with grant_valid.
REQ-019 Under continuous all-ones req with release every grant, owners SHALL be 0,1,...,31,0 with no requester skipped.

Reset
REQ-020 rst=1 SHALL immediately force state=IDLE, ptr=0, grant_valid=0, grant_idx=0, grant_onehot=0, timeout=0, hold counter=0, independent of clk.
REQ-021 rst asserted mid-grant SHALL drop the grant within the same cycle; after deassertion, arbitration SHALL restart from ptr=0.

Configuration
REQ-022 Macro ARB_TIMEOUT_EN defined: an 8-bit hold counter clears on grant entry and increments each GRANTED cycle; the grant SHALL be revoked after MAX_HOLD GRANTED cycles, with timeout pulsing high on the cycle the FSM returns to IDLE.
REQ-023 Macro ARB_TIMEOUT_EN undefined: no counter SHALL be built, timeout SHALL be tied to 0, and grants SHALL last until release or request drop.

Structure
REQ-024 Package arb_pkg SHALL hold N_REQ=32, IDX_W=5 and the state enum (IDLE, GRANTED).
REQ-025 Sub-module rr_pick_32 SHALL be purely combinational: inputs req[31:0] and ptr[4:0]; outputs any and idx[4:0] implementing the wrap-around search.

Verification
REQ-026 Reset then req=32'h0000_0001 -> grant_valid=1, grant_idx=0 one cycle later; release -> IDLE one cycle, then re-grant to 0.
REQ-027 req=32'hFFFF_FFFF with release 2 cycles after each grant -> grant_idx sequence 0..31 then 0; grant_onehot matches every cycle.
REQ-028 ptr=31 (after owner 30), req=32'h0000_0005 -> grant_idx=0, then 2 (wrap check).
REQ-029 Owner 3 drops req[3] while req[7]=1 -> IDLE next cycle, then grant_idx=7.
REQ-030 ARB_TIMEOUT_EN, MAX_HOLD=4, req[9] held with no release -> timeout pulse after 4 GRANTED cycles, then re-grant to 9; release and expiry in the same cycle -> timeout=0.
REQ-031 rst pulsed mid-grant of owner 12 -> outputs zero asynchronously; next grant searches from 0.
